// File: rtl/ahb_resp_mux_pkg.sv
// Shared encodings and helpers for the AHB response multiplexer.
package ahb_resp_mux_pkg;

    // Upper bound on attached subordinates; helpers work on vectors this wide.
    localparam int MaxSubs = 16;
    localparam int MaxIdxW = 4;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } resp_e;

    typedef enum logic [1:0] {
        DEF_IDLE = 2'd0,
        DEF_ERR1 = 2'd1,
        DEF_ERR2 = 2'd2
    } defState_e;

    // True when exactly one of the low 'width' bits of vec is set.
    function automatic logic onehotValid(input logic [MaxSubs-1:0] vec, input int width);
        int cnt;
        cnt = 32'sd0;
        for (int i = 32'sd0; i < MaxSubs; i++) begin
            if ((i < width) && vec[i]) begin
                cnt++;
            end
        end
        return (cnt == 32'sd1);
    endfunction

    // Index of the set bit; meaningful only when onehotValid() holds.
    function automatic logic [MaxIdxW-1:0] onehotIndex(input logic [MaxSubs-1:0] vec, input int width);
        logic [MaxIdxW-1:0] idx;
        idx = {MaxIdxW{1'b0}};
        for (int i = 32'sd0; i < MaxSubs; i++) begin
            if ((i < width) && vec[i]) begin
                idx = MaxIdxW'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ahb_resp_mux_if.sv
// Bus bundle between decoder/subordinates and the response multiplexer.
interface ahb_resp_mux_if
    import ahb_resp_mux_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int NumSubs   = 4
);
    logic [NumSubs-1:0]           sel;
    htrans_e                      htrans;
    logic [NumSubs*DataWidth-1:0] subRData;
    logic [NumSubs-1:0]           subReadyOut;
    logic [NumSubs-1:0]           subResp;
    logic [DataWidth-1:0]         rData;
    logic                         ready;
    logic                         resp;

    // The multiplexer side.
    modport slave (
        input  sel, htrans, subRData, subReadyOut, subResp,
        output rData, ready, resp
    );

    // The driving side (decoder, subordinates, manager).
    modport master (
        output sel, htrans, subRData, subReadyOut, subResp,
        input  rData, ready, resp
    );
endinterface

// File: rtl/ahb_resp_mux_default.sv
// Default subordinate: answers unmapped transfers with a two-cycle ERROR.
module ahb_default_sub
    import ahb_resp_mux_pkg::*;
(
    input  logic clk,
    input  logic nReset,
    input  logic start,
    output logic ready,
    output logic resp
);
    defState_e state_r;

    // Error sequencer with registered ready/resp decoded from the next state.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_r <= DEF_IDLE;
            ready   <= 1'b1;
            resp    <= RESP_OKAY;
        end else begin
            case (state_r)
                DEF_IDLE: begin
                    if (start) begin
                        state_r <= DEF_ERR1;
                        ready   <= 1'b0;
                        resp    <= RESP_ERROR;
                    end else begin
                        state_r <= DEF_IDLE;
                        ready   <= 1'b1;
                        resp    <= RESP_OKAY;
                    end
                end
                DEF_ERR1: begin
                    state_r <= DEF_ERR2;
                    ready   <= 1'b1;
                    resp    <= RESP_ERROR;
                end
                DEF_ERR2: begin
                    // A fresh bad address phase accepted here re-enters ERR1 directly.
                    if (start) begin
                        state_r <= DEF_ERR1;
                        ready   <= 1'b0;
                        resp    <= RESP_ERROR;
                    end else begin
                        state_r <= DEF_IDLE;
                        ready   <= 1'b1;
                        resp    <= RESP_OKAY;
                    end
                end
                default: begin
                    state_r <= DEF_IDLE;
                    ready   <= 1'b1;
                    resp    <= RESP_OKAY;
                end
            endcase
        end
    end
endmodule

// File: rtl/ahb_resp_mux.sv
// AHB data-phase response multiplexer with a built-in default subordinate.
module ahb_resp_mux
    import ahb_resp_mux_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int NumSubs   = 4
) (
    input logic           clk,
    input logic           nReset,
    ahb_resp_mux_if.slave bus
);
    localparam int IdxW = $clog2(NumSubs);

    logic [IdxW-1:0]      ownerIdx_r;
    logic                 ownerDef_r;
    logic                 active_r;
    logic                 selValid_s;
    logic                 isXfer_s;
    logic                 start_s;
    logic                 defReady_s;
    logic                 defResp_s;
    logic                 readyMux_s;
    logic                 respMux_s;
    logic [DataWidth-1:0] rDataMux_s;

    assign selValid_s = onehotValid(MaxSubs'(bus.sel), NumSubs);
    assign isXfer_s   = (bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ);
    // Kick the error sequencer on the same edge the default owner is captured.
    assign start_s    = readyMux_s && !selValid_s && isXfer_s;

    ahb_default_sub uDefaultSub (
        .clk    (clk),
        .nReset (nReset),
        .start  (start_s),
        .ready  (defReady_s),
        .resp   (defResp_s)
    );

    // Data-phase owner: captured only when the bus completes a transfer.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            ownerDef_r <= 1'b1;
            ownerIdx_r <= {IdxW{1'b0}};
            active_r   <= 1'b0;
        end else if (readyMux_s) begin
            if (selValid_s) begin
                ownerDef_r <= 1'b0;
                ownerIdx_r <= IdxW'(onehotIndex(MaxSubs'(bus.sel), NumSubs));
                active_r   <= 1'b1;
            end else if (isXfer_s) begin
                ownerDef_r <= 1'b1;
                ownerIdx_r <= {IdxW{1'b0}};
                active_r   <= 1'b1;
            end else begin
                // No valid select and no real transfer (multi-hot IDLE/BUSY included).
                ownerDef_r <= 1'b1;
                ownerIdx_r <= {IdxW{1'b0}};
                active_r   <= 1'b0;
            end
        end else begin
            ownerDef_r <= ownerDef_r;
            ownerIdx_r <= ownerIdx_r;
            active_r   <= active_r;
        end
    end

    // Zero-latency steering of the owning subordinate's response.
    always_comb begin
        rDataMux_s = {DataWidth{1'b0}};
        readyMux_s = 1'b1;
        respMux_s  = RESP_OKAY;
        if (ownerDef_r) begin
            if (active_r) begin
                readyMux_s = defReady_s;
                respMux_s  = defResp_s;
            end else begin
                readyMux_s = 1'b1;
                respMux_s  = RESP_OKAY;
            end
        end else begin
            rDataMux_s = bus.subRData[int'(ownerIdx_r) * DataWidth +: DataWidth];
            readyMux_s = bus.subReadyOut[ownerIdx_r];
            respMux_s  = bus.subResp[ownerIdx_r];
        end
    end

    assign bus.rData = rDataMux_s;
    assign bus.ready = readyMux_s;
    assign bus.resp  = respMux_s;
endmodule
